// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl - multi-cycle sequencing controller for the 16-bit-PC /
// 64-bit-word MIPS datapath. One memory access is in flight at a time, and
// each access waits for a ready handshake. The controller drives every
// datapath enable, counts retired instructions, and stops in HALT or ERROR.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_op, i_funct       IR opcode [29:24] and R-type function [5:0]
//   i_mem_ready         memory finished the current access this cycle
//   i_alu_zero          ALU zero flag, used by BEQ
//   o_mem_req/o_mem_we  memory request and write strobe
//   o_ir_write          IR load enable
//   o_pc_write          PC load enable
//   o_pc_src            PC source: 0 = PC+1, 1 = branch target, 2 = jump target
//   o_alu_src_b         ALU B input: 0 = readData2, 1 = sign-extended imm16
//   o_alu_ctrl          ALU operation
//   o_reg_write         register-file write enable
//   o_mem_to_reg        write-back source: 0 = ALU, 1 = memory
//   o_state             current state, for debug
//   o_halted, o_error   terminal state flags
//   o_retired           count of completed instructions, wraps modulo 2^32
//
// state  | meaning
// RESET  | leaving reset, no enables
// FETCH  | instruction read, waits for ready
// DECODE | opcode dispatch; JUMP completes here
// EXEC   | R-type ALU operation
// WB     | R-type register write-back
// ADDR   | effective address calculation
// MEM    | data load/store, waits for ready
// LWB    | load write-back
// BRANCH | BEQ compare and conditional PC load
// HALT   | stopped by HALT instruction
// ERROR  | illegal opcode or memory timeout
module mips_mc_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [5:0]  ALU_ADD = 6'd0,
    parameter logic [5:0]  ALU_SUB = 6'd1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic        i_mem_ready,
    input  logic        i_alu_zero,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_src,
    output logic        o_alu_src_b,
    output logic [5:0]  o_alu_ctrl,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic [3:0]  o_state,
    output logic        o_halted,
    output logic        o_error,
    output logic [31:0] o_retired
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM    = 4'd6,
        S_LWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9,
        S_ERROR  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LOAD  = 6'd1;
    localparam logic [5:0] OP_STORE = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd3;
    localparam logic [5:0] OP_JUMP  = 6'd4;
    localparam logic [5:0] OP_HALT  = 6'd63;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_retired;
    logic        w_retire;
    logic        w_timeout;

    // Last permitted wait cycle: no ready now means the access is abandoned.
    assign w_timeout = (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 2'd0;
        o_alu_src_b  = 1'b0;
        o_alu_ctrl   = 6'd0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_halted     = 1'b0;
        o_error      = 1'b0;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                case (i_op)
                    OP_RTYPE:         w_next = S_EXEC;
                    OP_LOAD, OP_STORE: w_next = S_ADDR;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_JUMP: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd2;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                    OP_HALT: begin
                        // HALT counts as retired exactly once, on entry.
                        w_retire = 1'b1;
                        w_next   = S_HALT;
                    end
                    default:          w_next = S_ERROR;
                endcase
            end
            S_EXEC: begin
                o_alu_ctrl = i_funct;
                w_next     = S_WB;
            end
            S_WB: begin
                o_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDR: begin
                o_alu_ctrl  = ALU_ADD;
                o_alu_src_b = 1'b1;
                w_next      = S_MEM;
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = (i_op == OP_STORE);
                if (i_mem_ready) begin
                    if (i_op == OP_STORE) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_LWB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_LWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_ctrl = ALU_SUB;
                if (i_alu_zero) begin
                    o_pc_write = 1'b1;
                    o_pc_src   = 2'd1;
                end
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  o_halted = 1'b1;
            S_ERROR: o_error  = 1'b1;
            default: w_next = S_ERROR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RESET;
            r_wait_cnt <= 8'd0;
            r_retired  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            // Every fresh access starts its own wait budget.
            if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state)) begin
                r_wait_cnt <= 8'd0;
            end else if (o_mem_req && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_retired = r_retired;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and popped/compared at the following falling edge.
module tb_mips_mc_ctrl;

    localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, EXE = 4'd3,
                           WB  = 4'd4, ADR = 4'd5, MEM = 4'd6, LWB = 4'd7,
                           BRN = 4'd8, HLT = 4'd9, ERR = 4'd10;
    localparam logic [5:0] ADD_C = 6'h20, SUB_C = 6'h22;

    typedef struct packed {
        logic [3:0]  st;
        logic        req, we, irw, pcw;
        logic [1:0]  src;
        logic        bsel;
        logic [5:0]  alu;
        logic        rw, m2r, hlt, err;
        logic [31:0] ret;
    } exp_t;

    typedef struct packed {
        logic [5:0] op, fn;
        logic       rdy, z;
        exp_t       ex;
    } vec_t;

    logic        clk, rst_n;
    logic [5:0]  op, fn;
    logic        rdy, z;
    logic        mem_req, mem_we, ir_write, pc_write, alu_src_b, reg_write, mem_to_reg, halted, error;
    logic [1:0]  pc_src;
    logic [5:0]  alu_ctrl;
    logic [3:0]  state;
    logic [31:0] retired;
    exp_t        obs, ex;
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    mips_mc_ctrl #(.TIMEOUT(4), .ALU_ADD(ADD_C), .ALU_SUB(SUB_C)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct(fn),
        .i_mem_ready(rdy), .i_alu_zero(z),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_write(ir_write),
        .o_pc_write(pc_write), .o_pc_src(pc_src), .o_alu_src_b(alu_src_b),
        .o_alu_ctrl(alu_ctrl), .o_reg_write(reg_write), .o_mem_to_reg(mem_to_reg),
        .o_state(state), .o_halted(halted), .o_error(error), .o_retired(retired)
    );

    assign obs = {state, mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b,
                  alu_ctrl, reg_write, mem_to_reg, halted, error, retired};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t e(input logic [3:0] st, input logic req, we, irw, pcw,
                               input logic [1:0] src, input logic bsel, input logic [5:0] alu,
                               input logic rw, m2r, input logic [31:0] ret);
        return {st, req, we, irw, pcw, src, bsel, alu, rw, m2r, (st == HLT), (st == ERR), ret};
    endfunction

    function automatic vec_t mv(input logic [5:0] o, f, input logic r, zz, input exp_t x);
        return {o, f, r, zz, x};
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        op = v.op; fn = v.fn; rdy = v.rdy; z = v.z;
        sb.push_back(v.ex);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; op = 6'd0; fn = 6'd0; rdy = 1'b0; z = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 6'd63; fn = 6'h3f; rdy = 1'b1; z = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e(RST,0,0,0,0,0,0,0,0,0,0));
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL reset_hold c%0d: got %h want %h", i, obs, ex);
            end
        end
        rst_n = 1'b1; rdy = 1'b0;
        sb.push_back(e(FET,1,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        ex = sb.pop_front(); n_vec++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, ex);
        end
    endtask

    task automatic test_rtype();
        vec_t q[$];
        do_reset();
        q.push_back(mv(0,5,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(0,5,0,0, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(0,5,1,1, e(EXE,0,0,0,0,0,0,5,0,0,0)));
        q.push_back(mv(0,5,1,0, e(WB ,0,0,0,0,0,0,0,1,0,0)));
        q.push_back(mv(0,5,0,0, e(FET,1,0,0,0,0,0,0,0,0,1)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL rtype c%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_load_store();
        vec_t q[$];
        do_reset();
        q.push_back(mv(1,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(1,0,0,0, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,1,0, e(ADR,0,0,0,0,0,1,ADD_C,0,0,0)));
        q.push_back(mv(1,0,0,0, e(MEM,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,0,0, e(MEM,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,1,0, e(MEM,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(1,0,1,0, e(LWB,0,0,0,0,0,0,0,1,1,0)));
        q.push_back(mv(2,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,1)));
        q.push_back(mv(2,0,0,0, e(DEC,0,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,0,0, e(ADR,0,0,0,0,0,1,ADD_C,0,0,1)));
        q.push_back(mv(2,0,0,0, e(MEM,1,1,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,0,0, e(MEM,1,1,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,1,0, e(MEM,1,1,0,0,0,0,0,0,0,1)));
        q.push_back(mv(2,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,2)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL load_store c%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_beq_jump();
        vec_t q[$];
        do_reset();
        q.push_back(mv(3,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(3,0,0,1, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(3,0,0,1, e(BRN,0,0,0,1,1,0,SUB_C,0,0,0)));
        q.push_back(mv(3,0,1,1, e(FET,1,0,1,1,0,0,0,0,0,1)));
        q.push_back(mv(3,0,0,1, e(DEC,0,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(3,0,0,0, e(BRN,0,0,0,0,0,0,SUB_C,0,0,1)));
        q.push_back(mv(4,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,2)));
        q.push_back(mv(4,0,0,0, e(DEC,0,0,0,1,2,0,0,0,0,2)));
        q.push_back(mv(4,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,3)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL beq_jump c%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t q[$];
        do_reset();
        q.push_back(mv(4,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(4,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(4,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(4,0,0,0, e(DEC,0,0,0,1,2,0,0,0,0,0)));
        for (int k = 0; k < 4; k++)
            q.push_back(mv(4,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(4,0,0,0, e(ERR,0,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(4,0,1,1, e(ERR,0,0,0,0,0,0,0,0,0,1)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL timeout c%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_illegal_halt();
        vec_t q[$];
        do_reset();
        q.push_back(mv(7,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(7,0,0,0, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(7,0,1,0, e(ERR,0,0,0,0,0,0,0,0,0,0)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL illegal c%0d: got %h want %h", i, obs, ex);
            end
        end
        q.delete();
        do_reset();
        q.push_back(mv(63,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(63,0,0,0, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(63,0,1,0, e(HLT,0,0,0,0,0,0,0,0,0,1)));
        q.push_back(mv(0,0,1,1,  e(HLT,0,0,0,0,0,0,0,0,0,1)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL halt c%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        vec_t q[$];
        do_reset();
        q.push_back(mv(2,0,1,0, e(FET,1,0,1,1,0,0,0,0,0,0)));
        q.push_back(mv(2,0,0,0, e(DEC,0,0,0,0,0,0,0,0,0,0)));
        q.push_back(mv(2,0,0,0, e(ADR,0,0,0,0,0,1,ADD_C,0,0,0)));
        q.push_back(mv(2,0,0,0, e(MEM,1,1,0,0,0,0,0,0,0,0)));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            ex = sb.pop_front(); n_vec++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL mid_mem c%0d: got %h want %h", i, obs, ex);
            end
        end
        // Reset lands between edges: outputs must clear without a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.push_back(e(RST,0,0,0,0,0,0,0,0,0,0));
        #1;
        ex = sb.pop_front(); n_vec++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL mid_mem_async_reset: got %h want %h", obs, ex);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(mv(2,0,0,0, e(FET,1,0,0,0,0,0,0,0,0,0)));
        @(negedge clk);
        ex = sb.pop_front(); n_vec++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL mid_mem_restart: got %h want %h", obs, ex);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_beq_jump();
        test_timeout();
        test_illegal_halt();
        test_reset_mid_mem();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle sequencing controller for the 16-bit-PC / 64-bit-word MIPS datapath (program counter, PC adder, instruction/data RAM, 64-entry register file, ALU). It replaces the free-running single-cycle flow with an FSM that issues one memory access at a time through a ready handshake and drives every datapath enable. It also retires instructions, detects illegal opcodes and memory timeouts, and stops on HALT.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ready before entering ERROR (1..255).
- ALU_ADD, 6'd0: ALU control code used for address calculation.
- ALU_SUB, 6'd1: ALU control code used for the branch compare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  IR[29:24] opcode, from the IR register written by ir_write.
- funct  in  6  IR[5:0] ALU function for R-type instructions.
- mem_ready  in  1  memory has completed the current access this cycle.
- alu_zero  in  1  ALU zero flag.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid only with mem_req.
- ir_write  out  1  load the IR from the read data.
- pc_write  out  1  load the PC.
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- alu_src_b  out  1  ALU B input: 0 = readData2, 1 = sign-extended imm16 (IR[45:30]).
- alu_ctrl  out  6  ALU operation.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source: 0 = ALU, 1 = memory.
- state  out  4  current state, for debug.
- halted  out  1  controller is in HALT.
- error  out  1  controller is in ERROR.
- retired  out  32  count of completed instructions.

## Operation
- State encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, WB=4, ADDR=5, MEM=6, LWB=7, BRANCH=8, HALT=9, ERROR=10.
- Opcodes: 0 R-type, 1 LOAD, 2 STORE, 3 BEQ, 4 JUMP, 63 HALT. Any other opcode is illegal.
- Outputs decode combinationally from state, op, funct, mem_ready and alu_zero.
- Any output not listed for a state is 0.

State behaviour:
- RESET: all outputs 0. Goes to FETCH unconditionally.
- FETCH: mem_req=1, mem_we=0. Stays until mem_ready.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: one cycle, no enables.
  - R-type → EXEC. LOAD/STORE → ADDR. BEQ → BRANCH. HALT → HALT. Illegal → ERROR.
  - JUMP: pc_write=1, pc_src=2, retire, → FETCH.
- EXEC: alu_ctrl=funct, alu_src_b=0 → WB.
- WB: reg_write=1, mem_to_reg=0, retire → FETCH.
- ADDR: alu_ctrl=ALU_ADD, alu_src_b=1 → MEM.
- MEM: mem_req=1, mem_we=(op==2). Stays until mem_ready.
  - On mem_ready, STORE: retire, → FETCH.
  - On mem_ready, LOAD: → LWB.
- LWB: reg_write=1, mem_to_reg=1, retire → FETCH.
- BRANCH: alu_ctrl=ALU_SUB, alu_src_b=0.
  - If alu_zero: pc_write=1, pc_src=1.
  - Always retire, → FETCH.
- HALT: halted=1, terminal. HALT itself is retired once, on entry.
- ERROR: error=1, terminal; not retired. Only rst_n leaves HALT or ERROR.

Wait counter and retire counter:
- An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 && !mem_ready.
- If mem_ready is still 0 when the counter reaches TIMEOUT-1, go to ERROR next edge; mem_req drops in ERROR.
- mem_ready outside FETCH/MEM is ignored.
- retired increments by 1 on each retire edge and wraps modulo 2^32.

## Timing
- Reset: asynchronous. All flops clear immediately when rst_n=0: state=RESET, wait counter=0, retired=0, so every output is 0. FETCH is entered on the first rising edge with rst_n=1.
- Reset mid-access: mem_req drops combinationally; the in-flight access is abandoned.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - R-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BEQ: 3 cycles.
  - JUMP: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake: mem_req stays high and mem_we stays stable from entry to FETCH/MEM until the cycle mem_ready is sampled high. The access completes on that edge.
- pc_write and ir_write in FETCH are asserted only in the mem_ready cycle (Mealy).
- BEQ decides on alu_zero sampled in the BRANCH cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0, state=0, retired=0. Release → state=1, mem_req=1 on the next cycle.
- R-type, op=0, funct=6'h05, zero-wait memory:
  - ir_write/pc_write pulse in cycle 1.
  - alu_ctrl=5 in EXEC.
  - reg_write=1 with mem_to_reg=0 in cycle 4.
  - retired=1.
- LOAD then STORE, mem_ready delayed 2 cycles each:
  - LOAD: LWB reg_write with mem_to_reg=1.
  - STORE: mem_we=1 held for 3 MEM cycles.
  - retired=2.
- BEQ: alu_zero=1 → pc_write=1, pc_src=1. Repeat with alu_zero=0 → pc_write=0. Both cases retire.
- TIMEOUT=4, mem_ready held 0 in FETCH → ERROR after exactly 4 request cycles: error=1, mem_req=0, retired unchanged.
- op=7 → ERROR from DECODE. op=63 → halted=1, retired+1. Assert rst_n=0 mid-MEM → immediate return to RESET.
